// File: rtl/gsim_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gsim_pkg : shared states, timing constants and widths for gsim_sched |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package gsim_pkg;

  localparam int ITER_W     = 7;
  localparam int ROW_W      = 2;
  localparam int COEF_W     = 16;
  localparam int XREG_W     = 32;
  localparam int NROWS      = 4;
  localparam int S_CYCLES   = 3;
  localparam int BUBBLES    = 2;
  localparam int DRAIN_CYC  = 2;
  localparam int ROW_PERIOD = 1 + S_CYCLES + BUBBLES + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INS   = 3'd1,
    ST_ROW_B = 3'd2,
    ST_ROW_S = 3'd3,
    ST_ROW_W = 3'd4,
    ST_ROW_M = 3'd5,
    ST_DRAIN = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  // Column order for the subtract phase: ascending, skipping the diagonal.
  function automatic logic [ROW_W-1:0] first_j(input logic [ROW_W-1:0] row);
    return (row == '0) ? ROW_W'(1) : ROW_W'(0);
  endfunction

  function automatic logic [ROW_W-1:0] next_j(input logic [ROW_W-1:0] row,
                                              input logic [ROW_W-1:0] j);
    logic [ROW_W-1:0] n;
    n = j + ROW_W'(1);
    if (n == row) n = n + ROW_W'(1);
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gsim_opsel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gsim_opsel : core operand selection with multiply-result forwarding  |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module gsim_opsel
  import gsim_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  s_en_i,
  input  logic                  m_en_i,
  input  logic [ROW_W-1:0]      row_i,
  input  logic [ROW_W-1:0]      j_i,
  input  logic [255:0]          i_a_mat,
  input  logic [63:0]           i_inv,
  input  logic [127:0]          i_x_data,
  input  logic [31:0]           i_mul_forw,
  input  logic [31:0]           i_sub_forw,
  output logic [31:0]           inst_a_o,
  output logic [15:0]           inst_b_o,
  output logic                  zero_o
);

  logic [COEF_W-1:0] w_a   [NROWS*NROWS];
  logic [COEF_W-1:0] w_inv [NROWS];
  logic [XREG_W-1:0] w_x   [NROWS];

  genvar gi;
  generate
    for (gi = 0; gi < NROWS*NROWS; gi++) begin : g_amat
      assign w_a[gi] = i_a_mat[COEF_W*gi +: COEF_W];
    end
    for (gi = 0; gi < NROWS; gi++) begin : g_vec
      assign w_inv[gi] = i_inv[COEF_W*gi +: COEF_W];
      assign w_x[gi]   = i_x_data[XREG_W*gi +: XREG_W];
    end
  endgenerate

  // Multiply result lands in the core 2 cycles after ROW_M; until then x is stale.
  logic             m_d1_q, m_d2_q;
  logic [ROW_W-1:0] idx_d1_q, idx_d2_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      m_d1_q   <= 1'b0;
      m_d2_q   <= 1'b0;
      idx_d1_q <= '0;
      idx_d2_q <= '0;
    end else begin
      m_d1_q   <= m_en_i;
      m_d2_q   <= m_d1_q;
      idx_d1_q <= row_i;
      idx_d2_q <= idx_d1_q;
    end
  end

  logic w_fwd;
  assign w_fwd = m_d2_q && (idx_d2_q == j_i);

  always_comb begin
    inst_a_o = '0;
    inst_b_o = '0;
    zero_o   = 1'b1;
    if (s_en_i) begin
      inst_a_o = w_fwd ? i_mul_forw : w_x[j_i];
      inst_b_o = w_a[{row_i, j_i}];
      zero_o   = 1'b0;
    end else if (m_en_i) begin
      inst_a_o = i_sub_forw;
      inst_b_o = w_inv[row_i];
      zero_o   = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gsim_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gsim_sched : Gauss-Seidel row scheduler driving the solver core      |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module gsim_sched
  import gsim_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [6:0]   i_iter,
  input  logic [63:0]  i_b,
  input  logic [255:0] i_a_mat,
  input  logic [63:0]  i_inv,
  input  logic [127:0] i_x_data,
  input  logic [31:0]  i_mul_forw,
  input  logic [31:0]  i_sub_forw,
  output logic [31:0]  o_inst_A,
  output logic [15:0]  o_inst_B,
  output logic [1:0]   o_idx,
  output logic         o_m_en,
  output logic         o_s_en,
  output logic         o_s_last,
  output logic         o_zero,
  output logic         o_b_ins,
  output logic [63:0]  o_b_ins_data,
  output logic         o_b_up,
  output logic [1:0]   o_b_up_idx,
  output logic [15:0]  o_b_up_data,
  output logic         o_busy,
  output logic         o_done
);

  state_t            state_q;
  logic [ROW_W-1:0]  row_q, j_q;
  logic [1:0]        cnt_q;
  logic [ITER_W-1:0] iter_q, n_q;
  logic              busy_q, done_q, b_ins_q, b_up_q, s_en_q, s_last_q, m_en_q;

  // Control outputs are registered: each edge computes the flags of the state it enters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      j_q      <= '0;
      cnt_q    <= '0;
      iter_q   <= '0;
      n_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      b_ins_q  <= 1'b0;
      b_up_q   <= 1'b0;
      s_en_q   <= 1'b0;
      s_last_q <= 1'b0;
      m_en_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      b_ins_q  <= 1'b0;
      b_up_q   <= 1'b0;
      s_en_q   <= 1'b0;
      s_last_q <= 1'b0;
      m_en_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q <= ST_INS;
            n_q     <= i_iter;
            iter_q  <= '0;
            row_q   <= '0;
            busy_q  <= 1'b1;
            b_ins_q <= 1'b1;
          end
        end
        ST_INS: begin
          if (n_q == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_ROW_B;
            row_q   <= '0;
            b_up_q  <= 1'b1;
          end
        end
        ST_ROW_B: begin
          state_q <= ST_ROW_S;
          cnt_q   <= '0;
          s_en_q  <= 1'b1;
          j_q     <= first_j(row_q);
        end
        ST_ROW_S: begin
          if (cnt_q == 2'(S_CYCLES - 1)) begin
            state_q <= ST_ROW_W;
            cnt_q   <= '0;
          end else begin
            cnt_q    <= cnt_q + 2'd1;
            s_en_q   <= 1'b1;
            s_last_q <= (cnt_q == 2'(S_CYCLES - 2));
            j_q      <= next_j(row_q, j_q);
          end
        end
        ST_ROW_W: begin
          if (cnt_q == 2'(BUBBLES - 1)) begin
            state_q <= ST_ROW_M;
            m_en_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        ST_ROW_M: begin
          cnt_q <= '0;
          if (row_q != ROW_W'(NROWS - 1)) begin
            state_q <= ST_ROW_B;
            row_q   <= row_q + ROW_W'(1);
            b_up_q  <= 1'b1;
          end else if ((iter_q + ITER_W'(1)) < n_q) begin
            state_q <= ST_ROW_B;
            row_q   <= '0;
            iter_q  <= iter_q + ITER_W'(1);
            b_up_q  <= 1'b1;
          end else begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (cnt_q == 2'(DRAIN_CYC - 1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  gsim_opsel u_opsel (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .s_en_i     (s_en_q),
    .m_en_i     (m_en_q),
    .row_i      (row_q),
    .j_i        (j_q),
    .i_a_mat    (i_a_mat),
    .i_inv      (i_inv),
    .i_x_data   (i_x_data),
    .i_mul_forw (i_mul_forw),
    .i_sub_forw (i_sub_forw),
    .inst_a_o   (o_inst_A),
    .inst_b_o   (o_inst_B),
    .zero_o     (o_zero)
  );

  assign o_s_en       = s_en_q;
  assign o_s_last     = s_last_q;
  assign o_m_en       = m_en_q;
  assign o_idx        = (s_en_q || m_en_q) ? row_q : '0;
  assign o_b_ins      = b_ins_q;
  assign o_b_ins_data = b_ins_q ? i_b : '0;
  assign o_b_up       = b_up_q;
  assign o_b_up_idx   = b_up_q ? row_q : '0;
  assign o_b_up_data  = b_up_q ? i_b[COEF_W*row_q +: COEF_W] : '0;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_gsim_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gsim_sched : directed self-checking bench for gsim_sched          |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module tb_gsim_sched;

  logic         i_clk = 1'b0;
  logic         i_reset, i_start;
  logic [6:0]   i_iter;
  logic [63:0]  i_b, i_inv;
  logic [255:0] i_a_mat;
  logic [127:0] i_x_data;
  logic [31:0]  i_mul_forw, i_sub_forw;
  logic [31:0]  o_inst_A;
  logic [15:0]  o_inst_B, o_b_up_data;
  logic [1:0]   o_idx, o_b_up_idx;
  logic         o_m_en, o_s_en, o_s_last, o_zero, o_b_ins, o_b_up, o_busy, o_done;
  logic [63:0]  o_b_ins_data;

  int cyc, n_pass, n_total, s_cnt, m_cnt, multi_cnt, done_cnt;

  always #5 i_clk = ~i_clk;

  gsim_sched dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_iter(i_iter),
    .i_b(i_b), .i_a_mat(i_a_mat), .i_inv(i_inv), .i_x_data(i_x_data),
    .i_mul_forw(i_mul_forw), .i_sub_forw(i_sub_forw),
    .o_inst_A(o_inst_A), .o_inst_B(o_inst_B), .o_idx(o_idx), .o_m_en(o_m_en),
    .o_s_en(o_s_en), .o_s_last(o_s_last), .o_zero(o_zero), .o_b_ins(o_b_ins),
    .o_b_ins_data(o_b_ins_data), .o_b_up(o_b_up), .o_b_up_idx(o_b_up_idx),
    .o_b_up_data(o_b_up_data), .o_busy(o_busy), .o_done(o_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    cyc++;
    s_cnt     += int'(o_s_en);
    m_cnt     += int'(o_m_en);
    done_cnt  += int'(o_done);
    if ((int'(o_b_ins) + int'(o_b_up) + int'(o_s_en) + int'(o_m_en)) > 1) multi_cnt++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic start_run(input logic [6:0] n);
    cyc = 0; s_cnt = 0; m_cnt = 0; multi_cnt = 0; done_cnt = 0;
    i_iter  = n;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
    chk({tag, "_zero"}, {63'd0, o_zero}, 64'd1);
    chk({tag, "_ctl"}, {58'd0, o_s_en, o_m_en, o_b_ins, o_b_up, o_done, o_s_last}, 64'd0);
    chk({tag, "_ops"}, {o_inst_A, o_inst_B, 16'd0}, 64'd0);
  endtask

  // Standard N=1 row-0/row-1 timing checks used before and after a mid-run reset.
  task automatic chk_n1_early(input string tag);
    chk({tag, "_ins"}, {63'd0, o_b_ins}, 64'd1);
    chk({tag, "_ins_data"}, o_b_ins_data, 64'h0100_0100_0100_0100);
    run_to(2);
    chk({tag, "_bup"}, {60'd0, o_b_up, o_b_up_idx, o_s_en}, {60'd0, 4'b1000});
    chk({tag, "_bup_data"}, {48'd0, o_b_up_data}, 64'h0100);
    run_to(3);
    chk({tag, "_s3"}, {o_inst_A, o_inst_B, 13'd0, o_s_en, o_s_last, o_zero},
        {32'hC000_0001, 16'hA001, 16'h0004});
    run_to(4);
    chk({tag, "_s4_b"}, {48'd0, o_inst_B}, 64'hA002);
    run_to(5);
    chk({tag, "_s5"}, {o_inst_A, o_inst_B, 14'd0, o_s_last, o_s_en},
        {32'hC000_0003, 16'hA003, 16'h0003});
    run_to(6);
    chk({tag, "_w6"}, {o_inst_A, o_inst_B, 14'd0, o_s_en, o_zero}, 64'h1);
    run_to(8);
    chk({tag, "_m8"}, {o_inst_A, o_inst_B, 11'd0, o_m_en, o_s_en, o_idx, o_zero},
        {32'h5B5B_0002, 16'h0E00, 16'h0010});
    run_to(10);
    chk({tag, "_s10_fwd"}, {o_inst_A, o_inst_B, 13'd0, o_idx, o_s_en},
        {32'hDEAD_0001, 16'hA010, 16'h0003});
    run_to(11);
    chk({tag, "_s11_x"}, {o_inst_A, o_inst_B, 16'd0}, {32'hC000_0002, 16'hA012, 16'd0});
    run_to(12);
    chk({tag, "_s12_x"}, {o_inst_A, o_inst_B, 15'd0, o_s_last},
        {32'hC000_0003, 16'hA013, 16'd1});
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_iter = '0;
    i_b        = {4{16'h0100}};
    i_mul_forw = 32'hDEAD_0001;
    i_sub_forw = 32'h5B5B_0002;
    for (int r = 0; r < 4; r++) begin
      i_inv[16*r +: 16]    = 16'h0E00 | 16'(r);
      i_x_data[32*r +: 32] = 32'hC000_0000 | 32'(r);
      for (int j = 0; j < 4; j++) i_a_mat[16*(4*r+j) +: 16] = 16'hA000 | 16'(16*r + j);
    end
    cyc = 0; n_pass = 0; n_total = 0;
    s_cnt = 0; m_cnt = 0; multi_cnt = 0; done_cnt = 0;

    repeat (3) @(posedge i_clk);
    #1;
    chk_idle("reset");
    i_reset = 1'b0;
    step();

    // N=1 full run with a start pulse that must be ignored.
    start_run(7'd1);
    chk("n1_busy1", {63'd0, o_busy}, 64'd1);
    chk_n1_early("n1");
    run_to(15);
    i_start = 1'b1; i_iter = 7'd0;
    step();
    i_start = 1'b0;
    run_to(29);
    chk("n1_m29", {45'd0, o_inst_B, o_m_en, o_idx}, {45'd0, 16'h0E03, 3'b111});
    run_to(31);
    chk("n1_done31", {62'd0, o_done, o_busy}, 64'h1);
    run_to(32);
    chk("n1_done32", {62'd0, o_done, o_busy}, 64'h3);
    run_to(33);
    chk("n1_idle33", {62'd0, o_done, o_busy}, 64'h0);
    chk("n1_counts", {16'(s_cnt), 16'(m_cnt), 16'(multi_cnt), 16'(done_cnt)},
        {16'd12, 16'd4, 16'd0, 16'd1});
    run_to(36);

    // N=0: no row operations.
    start_run(7'd0);
    chk("n0_ins", {62'd0, o_b_ins, o_busy}, 64'h3);
    run_to(2);
    chk("n0_done", {62'd0, o_done, o_busy}, 64'h3);
    run_to(5);
    chk("n0_counts", {16'(s_cnt), 16'(m_cnt), 16'(done_cnt), 15'd0, o_busy},
        {16'd0, 16'd0, 16'd1, 16'd0});

    // N=2: second iteration restarts at row 0.
    start_run(7'd2);
    run_to(30);
    chk("n2_bup30", {61'd0, o_b_up, o_b_up_idx}, 64'h4);
    run_to(59);
    chk("n2_done59", {62'd0, o_done, o_busy}, 64'h1);
    run_to(60);
    chk("n2_done60", {62'd0, o_done, o_busy}, 64'h3);
    chk("n2_counts", {16'(s_cnt), 16'(m_cnt), 16'(multi_cnt), 16'(done_cnt)},
        {16'd24, 16'd8, 16'd0, 16'd1});
    run_to(62);

    // Reset in the middle of ROW_S, then a fresh run.
    start_run(7'd1);
    run_to(4);
    chk("rst_pre_s", {63'd0, o_s_en}, 64'd1);
    i_reset = 1'b1;
    #1;
    chk_idle("rst_mid");
    step();
    chk_idle("rst_held");
    i_reset = 1'b0;
    step();
    start_run(7'd1);
    chk_n1_early("post");
    run_to(32);
    chk("post_done32", {62'd0, o_done, o_busy}, 64'h3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gsim_sched.md
GSIM_SCHED -- requirements
Module: gsim_sched

Interface
REQ-001 SHALL have: i_clk  in  1  clock; all state changes on rising edge.
REQ-002 SHALL have: i_reset  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: i_start  in  1  solve request; sampled only in IDLE.
REQ-004 SHALL have: i_iter  in  7  unsigned iteration count N, latched on accepted start.
REQ-005 SHALL have: i_b  in  64  signed 16-bit b_r at bits [16r+:16]; stable while o_busy.
REQ-006 SHALL have: i_a_mat  in  256  signed 16-bit a_rj at bits [16(4r+j)+:16]; stable while o_busy.
REQ-007 SHALL have: i_inv  in  64  16-bit reciprocal of a_rr at bits [16r+:16]; stable while o_busy.
REQ-008 SHALL have: i_x_data  in  128  core x registers, x_j at bits [32j+:32].
REQ-009 SHALL have: i_mul_forw / i_sub_forw  in  32 each  core multiply / last-subtract forwarding values.
REQ-010 SHALL have: o_inst_A  out  32  and  o_inst_B  out  16  core operands.
REQ-011 SHALL have: o_idx  out  2  target row; o_m_en, o_s_en, o_s_last, o_zero  out  1 each  core op controls.
REQ-012 SHALL have: o_b_ins  out  1  and  o_b_ins_data  out  64  b broadcast to all x.
REQ-013 SHALL have: o_b_up  out  1, o_b_up_idx  out  2, o_b_up_data  out  16  single-row b reload.
REQ-014 SHALL have: o_busy  out  1  high from start acceptance through the o_done cycle; o_done  out  1  single-cycle completion pulse.

Function
REQ-015 States SHALL be IDLE, INS, ROW_B, ROW_S, ROW_W, ROW_M, DRAIN, DONE; start accepted at edge 0 -> INS in cycle 1.
REQ-016 INS SHALL assert o_b_ins one cycle with o_b_ins_data = i_b; then N=0 -> DONE, else ROW_B with row 0.
REQ-017 ROW_B SHALL assert o_b_up one cycle, o_b_up_idx = row, o_b_up_data = b_row.
REQ-018 ROW_S SHALL take 3 cycles, o_s_en=1, o_idx=row, j ascending over {0..3}\{row}, o_inst_B=a_row,j, o_s_last=1 on third only.
REQ-019 Subtract o_inst_A SHALL be i_mul_forw when issued exactly 2 cycles after ROW_M of index j, otherwise i_x_data[32j+:32].
REQ-020 ROW_W SHALL be 2 bubble cycles; ROW_M SHALL be 1 cycle: o_m_en=1, o_idx=row, o_inst_A=i_sub_forw, o_inst_B=inv_row.
REQ-021 Row period SHALL be exactly 7 cycles (B,S,S,S,W,W,M); row r of iteration k (0-based) starts in cycle 2+28k+7r.
REQ-022 After ROW_M: row<3 -> ROW_B(row+1); row=3, iteration<N-1 -> ROW_B(row 0), iteration+1; else DRAIN.
REQ-023 DRAIN SHALL last 2 cycles; DONE pulses o_done for 1 cycle, then IDLE; o_done for N>=1 in cycle 4+28N.
REQ-024 In every cycle without s_en/m_en, o_zero SHALL be 1, o_inst_A/o_inst_B SHALL be 0.
REQ-025 i_start while busy SHALL be ignored; i_iter=0 SHALL complete in cycle 2 with no row operations.
REQ-026 At most one of o_b_ins, o_b_up, o_s_en, o_m_en SHALL be high in any cycle.

Reset
REQ-027 On i_reset (including mid-row) state SHALL go IDLE; all outputs 0 except o_zero=1; counters cleared.
REQ-028 After reset release the first start SHALL behave identically to a fresh power-up run.

Structure
REQ-029 State encoding, row period (7), bubble count (2), drain count (2), widths SHALL live in shared package gsim_pkg.
REQ-030 Operand selection (REQ-019/020) SHALL be sub-module gsim_opsel; FSM and counters stay in gsim_sched.

Verification
REQ-031 Reset asserted mid ROW_S -> next cycle o_s_en=0, o_zero=1, o_busy=0.
REQ-032 N=1, b=all 0x0100 -> o_b_ins cycle 1, row0 o_b_up cycle 2, S cycles 3-5 (B=a01,a02,a03, s_last at 5), M cycle 8, o_done cycle 32.
REQ-033 N=1 -> row1 first S (cycle 10, j=0) o_inst_A equals i_mul_forw; cycles 11,12 use i_x_data slices.
REQ-034 N=2 -> row0 of iteration 1 o_b_up at cycle 30, o_done cycle 60.
REQ-035 N=0 -> o_b_ins cycle 1, o_done cycle 2, no s_en/m_en ever.
REQ-036 i_start pulsed at cycle 15 during N=1 run -> ignored; o_done only at cycle 32.
